// File: rtl/cr_pkt_queue_enq.sv
// Write side of the per-flow retransmit packet queue: enqueues (seq, tx_id) entries with
// duplicate-seq filtering, applies the transmit processor's pops, and exports the packed context.
module cr_pkt_queue_enq #(
  parameter int unsigned IND_W  = 3,
  parameter int unsigned SEQ_W  = 16,
  parameter int unsigned TXID_W = 4,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned DEPTH = 2 ** IND_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [SEQ_W-1:0]        enq_seq,
  input  logic [TXID_W-1:0]       enq_tx_id,
  input  logic                    deq,
  input  logic                    flush,
  output logic [DEPTH*SEQ_W-1:0]  pkt_queue,
  output logic [DEPTH*TXID_W-1:0] tx_id_queue,
  output logic [IND_W-1:0]        head,
  output logic [IND_W-1:0]        size,
  output logic                    enq_done,
  output logic                    enq_dup,
  output logic [CNT_W-1:0]        dup_cnt,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam logic [IND_W-1:0] IndOne  = IND_W'(1);
  localparam logic [IND_W-1:0] SizeMax = '1;

  logic [SEQ_W-1:0]  seq_mem_q [DEPTH];
  logic [TXID_W-1:0] txid_mem_q [DEPTH];
  logic [IND_W-1:0]  head_q, size_q;
  logic              done_q, dup_q;
  logic [CNT_W-1:0]  dup_cnt_q, drop_cnt_q;

  logic              accept;
  logic              is_dup;
  logic              do_write;
  logic              do_deq;
  logic              drop;
  logic [IND_W-1:0]  tail;

  assign enq_ready = rst_n && !flush && (size_q != SizeMax);
  assign accept    = enq_valid && enq_ready;
  assign drop      = enq_valid && !enq_ready && !flush;
  assign tail      = head_q + size_q;
  assign do_write  = accept && !is_dup;
  assign do_deq    = deq && (size_q != '0);

  // Compare against every occupied slot, oldest first, using state before this cycle's pop.
  always_comb begin
    is_dup = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(size_q) && seq_mem_q[head_q + IND_W'(k)] == enq_seq) begin
        is_dup = 1'b1;
      end
    end
    if (!accept) begin
      is_dup = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      size_q     <= '0;
      done_q     <= 1'b0;
      dup_q      <= 1'b0;
      dup_cnt_q  <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        seq_mem_q[i]  <= '0;
        txid_mem_q[i] <= '0;
      end
    end else begin
      done_q <= accept;
      dup_q  <= is_dup;

      if (flush) begin
        head_q <= '0;
        size_q <= '0;
      end else begin
        if (do_write) begin
          seq_mem_q[tail]  <= enq_seq;
          txid_mem_q[tail] <= enq_tx_id;
        end
        if (do_deq) begin
          head_q <= head_q + IndOne;
        end
        unique case ({do_write, do_deq})
          2'b10:   size_q <= size_q + IndOne;
          2'b01:   size_q <= size_q - IndOne;
          default: size_q <= size_q;
        endcase
      end

      if (is_dup && dup_cnt_q != '1) begin
        dup_cnt_q <= dup_cnt_q + CNT_W'(1);
      end
      if (drop && drop_cnt_q != '1) begin
        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign pkt_queue[g*SEQ_W +: SEQ_W]     = seq_mem_q[g];
    assign tx_id_queue[g*TXID_W +: TXID_W] = txid_mem_q[g];
  end

  assign head     = head_q;
  assign size     = size_q;
  assign enq_done = done_q;
  assign enq_dup  = dup_q;
  assign dup_cnt  = dup_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cr_pkt_queue_enq.sv
// Directed bench for cr_pkt_queue_enq: enq_done/enq_dup checked by a scoreboard monitor,
// queue context and counters checked at fixed points of the stimulus.
module tb_cr_pkt_queue_enq;

  localparam int IND_W  = 3;
  localparam int SEQ_W  = 16;
  localparam int TXID_W = 4;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    enq_valid;
  logic                    enq_ready;
  logic [SEQ_W-1:0]        enq_seq;
  logic [TXID_W-1:0]       enq_tx_id;
  logic                    deq;
  logic                    flush;
  logic [DEPTH*SEQ_W-1:0]  pkt_queue;
  logic [DEPTH*TXID_W-1:0] tx_id_queue;
  logic [IND_W-1:0]        head;
  logic [IND_W-1:0]        size;
  logic                    enq_done;
  logic                    enq_dup;
  logic [CNT_W-1:0]        dup_cnt;
  logic [CNT_W-1:0]        drop_cnt;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  cr_pkt_queue_enq #(
    .IND_W (IND_W),
    .SEQ_W (SEQ_W),
    .TXID_W(TXID_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_valid  (enq_valid),
    .enq_ready  (enq_ready),
    .enq_seq    (enq_seq),
    .enq_tx_id  (enq_tx_id),
    .deq        (deq),
    .flush      (flush),
    .pkt_queue  (pkt_queue),
    .tx_id_queue(tx_id_queue),
    .head       (head),
    .size       (size),
    .enq_done   (enq_done),
    .enq_dup    (enq_dup),
    .dup_cnt    (dup_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    return 32'(pkt_queue[i*SEQ_W +: SEQ_W]);
  endfunction

  function automatic logic [31:0] txslot(input int i);
    return 32'(tx_id_queue[i*TXID_W +: TXID_W]);
  endfunction

  // Scoreboard monitor: every enq_done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (enq_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_enq_done", 32'(enq_done), 32'd0);
      end else begin
        chk("enq_dup", 32'(enq_dup), 32'(exp_q.pop_front()));
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic enq(input int s, input int t, input bit dup);
    int n = 0;
    enq_valid = 1'b1;
    enq_seq   = SEQ_W'(s);
    enq_tx_id = TXID_W'(t);
    @(negedge clk);
    while (!enq_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!enq_ready) chk("enq_ready_timeout", 32'(enq_ready), 32'd1);
    else exp_q.push_back(dup);
    @(posedge clk);
    #1 enq_valid = 1'b0;
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) begin
      deq = 1'b1;
      @(posedge clk);
      #1 deq = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; enq_valid = 1'b0; enq_seq = '0; enq_tx_id = '0; deq = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_head", 32'(head), 0);
    chk("rst_size", 32'(size), 0);
    chk("rst_pkt_queue", 32'(pkt_queue != '0), 0);
    chk("rst_tx_id_queue", 32'(tx_id_queue != '0), 0);
    chk("rst_enq_done", 32'(enq_done), 0);
    chk("rst_cnts", 32'(dup_cnt) + 32'(drop_cnt), 0);
    chk("rst_enq_ready", 32'(enq_ready), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    enq(10, 0, 0); enq(11, 1, 0); enq(12, 2, 0);
    chk("fill3_head", 32'(head), 0);
    chk("fill3_size", 32'(size), 3);
    chk("slot0", slot(0), 10);
    chk("slot1", slot(1), 11);
    chk("slot2", slot(2), 12);
    chk("txslot2", txslot(2), 2);

    enq(11, 5, 1);
    chk("dup_size", 32'(size), 3);
    chk("dup_cnt1", 32'(dup_cnt), 1);
    chk("dup_txslot1", txslot(1), 1);

    enq(13, 3, 0); enq(14, 4, 0); enq(15, 5, 0); enq(16, 6, 0);
    chk("full_size", 32'(size), 7);
    chk("full_ready", 32'(enq_ready), 0);
    enq_valid = 1'b1;
    enq_seq   = 16'd99;
    repeat (4) @(posedge clk);
    #1 enq_valid = 1'b0;
    chk("drop_cnt4", 32'(drop_cnt), 4);
    deq = 1'b1;
    #1 chk("full_ready_with_deq", 32'(enq_ready), 0);
    @(posedge clk);
    #1 deq = 1'b0;
    chk("after_deq_ready", 32'(enq_ready), 1);
    chk("after_deq_head", 32'(head), 1);
    chk("after_deq_size", 32'(size), 6);
    chk("vacated_slot0", slot(0), 10);

    pop(4);
    enq(17, 7, 0);
    chk("slot7", slot(7), 17);
    pop(2);
    chk("head7", 32'(head), 7);
    enq(18, 8, 0);
    chk("wrap_slot0", slot(0), 18);
    chk("wrap_size", 32'(size), 2);
    pop(1);
    chk("head_wrap0", 32'(head), 0);
    chk("head_wrap_size", 32'(size), 1);
    enq(18, 9, 1);
    chk("dup_cnt2", 32'(dup_cnt), 2);

    enq(19, 1, 0);
    enq_valid = 1'b1; enq_seq = 16'd20; enq_tx_id = 4'd2; deq = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1 enq_valid = 1'b0; deq = 1'b0;
    chk("simul_head", 32'(head), 1);
    chk("simul_size", 32'(size), 2);
    chk("simul_slot2", slot(2), 20);

    pop(3);
    chk("empty_deq_head", 32'(head), 3);
    chk("empty_deq_size", 32'(size), 0);

    enq(21, 3, 0);
    enq_valid = 1'b1; enq_seq = 16'd30; flush = 1'b1;
    @(posedge clk);
    #1 enq_valid = 1'b0; flush = 1'b0;
    chk("flush_head", 32'(head), 0);
    chk("flush_size", 32'(size), 0);
    chk("flush_drop_cnt", 32'(drop_cnt), 4);
    chk("flush_dup_cnt", 32'(dup_cnt), 2);
    @(posedge clk);
    #1 chk("flush_no_done", 32'(enq_done), 0);

    enq(40, 4, 0);
    enq(41, 5, 0);
    enq_valid = 1'b1; enq_seq = 16'd42; rst_n = 1'b0;
    @(posedge clk);
    #1 enq_valid = 1'b0;
    chk("mid_rst_head", 32'(head), 0);
    chk("mid_rst_size", 32'(size), 0);
    chk("mid_rst_pkt_queue", 32'(pkt_queue != '0), 0);
    chk("mid_rst_tx_id_queue", 32'(tx_id_queue != '0), 0);
    chk("mid_rst_done", 32'(enq_done), 0);
    chk("mid_rst_dup_cnt", 32'(dup_cnt), 0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
